// File: rtl/multdiv_pkg.sv
// Shared multiply/divide definitions: default width, controller states, step count.
package multdiv_pkg;
   localparam int MULT_WIDTH = 32;
   localparam int MULT_ITERS = MULT_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_e;
endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M, then arithmetic shift right.
module booth_step
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic [2*WIDTH:0] p_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [2*WIDTH:0] p_o
);

   logic [WIDTH:0] hi;
   logic [WIDTH:0] mx;
   logic [WIDTH:0] sum;

   always_comb begin
      hi = {p_i[2*WIDTH], p_i[2*WIDTH:WIDTH+1]};
      mx = {m_i[WIDTH-1], m_i};
      unique case (p_i[1:0])
         2'b01:   sum = hi + mx;
         2'b10:   sum = hi - mx;
         default: sum = hi;
      endcase
      // sum[WIDTH] is the true sign even when the add overflows WIDTH bits
      p_o = {sum, p_i[WIDTH:1]};
   end

endmodule

// File: rtl/mult_booth_ctrl.sv
// Sequential signed Booth multiplier controller, one bit per cycle.
// Define MULT_OVF_EN to flag products that do not fit in WIDTH signed bits.
module mult_booth_ctrl
   import multdiv_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ctrl_MULT,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   mult_state_e      state_q, state_d;
   logic [2*WIDTH:0] p_q, p_d, p_step;
   logic [WIDTH-1:0] m_q, m_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rdy;

   booth_step #(.WIDTH(WIDTH)) u_step (
      .p_i (p_q),
      .m_i (m_q),
      .p_o (p_step)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= IDLE;
         p_q     <= '0;
         m_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         m_q     <= m_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      m_d     = m_q;
      cnt_d   = cnt_q;
      rdy     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ctrl_MULT) begin
               m_d     = data_operandA;
               p_d     = {{WIDTH{1'b0}}, data_operandB, 1'b0};
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            p_d = p_step;
            if (cnt_q == LAST) state_d = DONE;
            else               cnt_d   = cnt_q + 1'b1;
         end
         DONE: begin
            rdy     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_result    = p_q[WIDTH:1];
   assign data_resultRDY = rdy;
   assign busy           = (state_q != IDLE);

`ifdef MULT_OVF_EN
   // Representable iff the upper half agrees with the result's sign bit
   logic [WIDTH:0] hi_bits;
   assign hi_bits        = p_q[2*WIDTH:WIDTH];
   assign data_exception = ~((&hi_bits) | ~(|hi_bits));
`else
   assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_mult_booth_ctrl.sv
// Scoreboard bench for mult_booth_ctrl: directed vectors plus random products.
module tb_mult_booth_ctrl;

   localparam int W   = 32;
   localparam int LAT = W + 1;
`ifdef MULT_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   typedef struct {
      logic [W-1:0] res;
      logic         exc;
      int           issue;
   } exp_t;

   logic         clk = 1'b0;
   logic         clr;
   logic         ctrl_MULT;
   logic [W-1:0] opa, opb;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;
   logic         busy;

   int   cyc = 0;
   int   checks = 0;
   int   fails = 0;
   exp_t sbq[$];

   mult_booth_ctrl #(.WIDTH(W)) dut (
      .clk            (clk),
      .clr            (clr),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (opa),
      .data_operandB  (opb),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic e);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      e = (p != longint'($signed(p[W-1:0])));
   endfunction

   // Monitor: every RDY pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (data_resultRDY) begin
         if (sbq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rdy: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("result", 64'(data_result), 64'(e.res));
            chk("exception", 64'(data_exception), 64'(e.exc & OVF_ON));
            chk("latency", 64'(cyc - e.issue), 64'(LAT));
            chk("busy_in_done", 64'(busy), 64'd1);
         end
      end
   end

   // Called at posedge+1; returns at the following posedge+1
   task automatic start(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic e,
                        input bit push, output int issue);
      exp_t x;
      ctrl_MULT = 1'b1;
      opa       = a;
      opb       = b;
      issue     = cyc;
      if (push) begin
         x.res   = r;
         x.exc   = e;
         x.issue = cyc;
         sbq.push_back(x);
      end
      @(posedge clk);
      #1;
      ctrl_MULT = 1'b0;
      opa       = $urandom;
      opb       = $urandom;
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sbq.size() != 0 || busy) && n < 200) begin
         @(posedge clk);
         n++;
      end
      #1;
      if (n >= 200) begin
         checks++;
         fails++;
         $display("FAIL timeout: got busy=%0b pending=%0d expected idle", busy, sbq.size());
         sbq.delete();
      end
   endtask

   initial begin
      int          iss;
      logic [W-1:0] ra, rb, rr;
      logic         re;

      clr       = 1'b1;
      ctrl_MULT = 1'b0;
      opa       = '0;
      opb       = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_result", 64'(data_result), 64'd0);
      chk("rst_exception", 64'(data_exception), 64'd0);
      chk("rst_rdy", 64'(data_resultRDY), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      clr = 1'b0;

      start(32'd3, 32'd4, 32'h0000_000C, 1'b0, 1'b1, iss);
      chk("busy_run", 64'(busy), 64'd1);
      wait_done();
      start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, iss);
      wait_done();
      start(32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 1'b1, iss);
      wait_done();
      start(32'h7FFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b1, 1'b1, iss);
      wait_done();
      start(32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1, iss);
      wait_done();
      start(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0, 1'b1, iss);
      wait_done();

      // Restart while running must be ignored
      start(32'd5, 32'd6, 32'h0000_001E, 1'b0, 1'b1, iss);
      repeat (9) @(posedge clk);
      #1;
      ctrl_MULT = 1'b1;
      opa       = 32'd7;
      opb       = 32'd7;
      @(posedge clk);
      #1;
      ctrl_MULT = 1'b0;
      wait_done();

      // Start coincident with DONE must be ignored
      start(32'd9, 32'd9, 32'h0000_0051, 1'b0, 1'b1, iss);
      repeat (32) @(posedge clk);
      #1;
      ctrl_MULT = 1'b1;
      opa       = 32'd1;
      opb       = 32'd1;
      @(posedge clk);
      #1;
      ctrl_MULT = 1'b0;
      chk("done_start_ignored", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("still_idle", 64'(busy), 64'd0);
      chk("result_held", 64'(data_result), 64'h51);

      // Reset mid-run, then immediate restart
      start(32'd5, 32'd6, 32'd0, 1'b0, 1'b0, iss);
      repeat (14) @(posedge clk);
      #1;
      clr = 1'b1;
      #2;
      chk("clr_busy", 64'(busy), 64'd0);
      chk("clr_result", 64'(data_result), 64'd0);
      chk("clr_exception", 64'(data_exception), 64'd0);
      chk("clr_rdy", 64'(data_resultRDY), 64'd0);
      clr = 1'b0;
      start(32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0, 1'b1, iss);
      wait_done();

      for (int i = 0; i < 1000; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = 32'($signed(rb) >>> 16);
         model(ra, rb, rr, re);
         start(ra, rb, rr, re, 1'b1, iss);
         wait_done();
      end

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
